// File: rtl/emmc_link_framer.sv
// emmc_link_framer: buffers {CMD,DAT[7:0]} samples and emits SYNC/COUNT/payload framed bytes to a serdes.
// Optional trailing CRC-8 byte is built only when EMMC_FRAMER_CRC_EN is defined.
module emmc_link_framer #(
  parameter int         FIFO_DEPTH  = 8,
  parameter int         MAX_SAMPLES = 4,
  parameter logic [7:0] IDLE_BYTE   = 8'h3C,
  parameter logic [7:0] SYNC_BYTE   = 8'hA5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sample_valid,
  input  logic        cmd_i,
  input  logic [7:0]  sd_dat_i,
  output logic        in_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        overflow,
  output logic [15:0] frame_cnt
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  typedef enum logic [2:0] {IDLE, SYNC, COUNT, PAY_HI, PAY_LO, CRC} state_t;
  state_t state_q, state_d;
  logic [8:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_q, rd_q, rd_nx;
  logic [CW-1:0] cnt_q;
  logic [3:0] rem_q, rem_d;
  logic [7:0] tx_q, tx_d;
  logic [15:0] fcnt_q;
  logic run_q, ovf_q, full, push, hs, pop, last, done;
  assign full = cnt_q == CW'(FIFO_DEPTH);
  assign push = sample_valid & ~full;
  assign hs = run_q & tx_ready;
  assign pop = hs & (state_q == PAY_LO);
  assign last = rem_q == 4'd1;
  assign rd_nx = rd_q + AW'(1);
  assign in_ready = run_q & ~full;
  assign tx_valid = run_q;
  assign tx_data = tx_q;
  assign overflow = ovf_q;
  assign frame_cnt = fcnt_q;
`ifdef EMMC_FRAMER_CRC_EN
  logic [7:0] crc_q, crc_nx;
  function automatic logic [7:0] crc8(input logic [7:0] c, input logic [7:0] b);
    logic [7:0] r;
    r = c ^ b;
    for (int i = 0; i < 8; i++) r = r[7] ? {r[6:0], 1'b0} ^ 8'h07 : {r[6:0], 1'b0};
    return r;
  endfunction
  assign crc_nx = crc8(crc_q, tx_q);
  assign done = hs & (state_q == CRC);
  // CRC covers the byte leaving in COUNT/PAY_HI/PAY_LO; anything else restarts it
  always_ff @(posedge clk or posedge rst)
    if (rst) crc_q <= 8'h00;
    else if (hs) crc_q <= (state_q == COUNT || state_q == PAY_HI || state_q == PAY_LO) ? crc_nx : 8'h00;
`else
  assign done = pop & last;
`endif
  always_ff @(posedge clk)
    if (push) mem_q[wr_q] <= {cmd_i, sd_dat_i};
  // tx_d is the byte belonging to the state being entered, so tx_data is fully registered
  always_comb begin
    state_d = state_q;
    tx_d = tx_q;
    rem_d = rem_q;
    if (hs)
      case (state_q)
        IDLE: if (cnt_q != '0) begin
          state_d = SYNC;
          tx_d = SYNC_BYTE;
          rem_d = (cnt_q > CW'(MAX_SAMPLES)) ? 4'(MAX_SAMPLES) : 4'(cnt_q);
        end
        SYNC: begin
          state_d = COUNT;
          tx_d = {4'h0, rem_q};
        end
        COUNT: begin
          state_d = PAY_HI;
          tx_d = {7'h00, mem_q[rd_q][8]};
        end
        PAY_HI: begin
          state_d = PAY_LO;
          tx_d = mem_q[rd_q][7:0];
        end
        PAY_LO: begin
          rem_d = rem_q - 4'd1;
          if (!last) begin
            state_d = PAY_HI;
            tx_d = {7'h00, mem_q[rd_nx][8]};
          end else begin
`ifdef EMMC_FRAMER_CRC_EN
            state_d = CRC;
            tx_d = crc_nx;
`else
            state_d = IDLE;
            tx_d = IDLE_BYTE;
`endif
          end
        end
        default: begin
          state_d = IDLE;
          tx_d = IDLE_BYTE;
        end
      endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      tx_q <= IDLE_BYTE;
      rem_q <= '0;
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
      ovf_q <= 1'b0;
      fcnt_q <= '0;
    end else begin
      state_q <= state_d;
      tx_q <= tx_d;
      rem_q <= rem_d;
      wr_q <= wr_q + AW'(push);
      rd_q <= rd_q + AW'(pop);
      cnt_q <= cnt_q + CW'(push) - CW'(pop);
      run_q <= 1'b1;
      ovf_q <= ovf_q | (sample_valid & full);
      fcnt_q <= fcnt_q + 16'(done);
    end
endmodule

// File: tb/tb_emmc_link_framer.sv
// tb_emmc_link_framer: queue-based frame model checked every cycle, plus directed literal frames.
module tb_emmc_link_framer;
  localparam int D = 8;
  localparam int M = 4;
  localparam logic [7:0] IB = 8'h3C;
  localparam logic [7:0] SB = 8'hA5;
`ifdef EMMC_FRAMER_CRC_EN
  localparam int CB = 1;
`else
  localparam int CB = 0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sample_valid = 1'b0;
  logic cmd_i = 1'b0;
  logic [7:0] sd_dat_i = 8'h00;
  logic tx_ready = 1'b0;
  logic in_ready, tx_valid, overflow;
  logic [7:0] tx_data;
  logic [15:0] frame_cnt;
  emmc_link_framer dut (
    .clk(clk), .rst(rst), .sample_valid(sample_valid), .cmd_i(cmd_i), .sd_dat_i(sd_dat_i),
    .in_ready(in_ready), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .overflow(overflow), .frame_cnt(frame_cnt)
  );
  always #5 clk = ~clk;
  int errs = 0;
  int checks = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  // model: sample queue, pending frame bytes with a kind tag (0 sync,1 count,2 hi,3 lo,4 crc)
  logic [8:0] q[$];
  logic [7:0] fb[$];
  int fk[$];
  bit mvalid = 1'b0;
  bit movf = 1'b0;
  logic [15:0] mframes = 16'h0;
  logic [7:0] txlog[$];
`ifdef EMMC_FRAMER_CRC_EN
  function automatic logic [7:0] crc_ref(input logic [7:0] b[$]);
    logic [7:0] c;
    logic fbk;
    c = 8'h00;
    foreach (b[j])
      for (int k = 7; k >= 0; k--) begin
        fbk = c[7] ^ b[j][k];
        c = {c[6:0], 1'b0};
        if (fbk) c = c ^ 8'h07;
      end
    return c;
  endfunction
`endif
  task automatic model_reset();
    q.delete();
    fb.delete();
    fk.delete();
    mvalid = 1'b0;
    movf = 1'b0;
    mframes = 16'h0;
  endtask
  task automatic model_step();
    int s0;
    int n;
    bit hs;
    logic [7:0] body[$];
    s0 = q.size();
    hs = mvalid && tx_ready;
    if (hs) begin
      if (fb.size() == 0) begin
        if (s0 > 0) begin
          n = s0 < M ? s0 : M;
          fb.push_back(SB); fk.push_back(0);
          body.push_back(8'(n));
          fb.push_back(8'(n)); fk.push_back(1);
          for (int i = 0; i < n; i++) begin
            body.push_back({7'h00, q[i][8]});
            body.push_back(q[i][7:0]);
            fb.push_back({7'h00, q[i][8]}); fk.push_back(2);
            fb.push_back(q[i][7:0]); fk.push_back(3);
          end
`ifdef EMMC_FRAMER_CRC_EN
          fb.push_back(crc_ref(body)); fk.push_back(4);
`endif
        end
      end else begin
        if (fk[0] == 3) void'(q.pop_front());
        void'(fb.pop_front());
        void'(fk.pop_front());
        if (fb.size() == 0) mframes++;
      end
    end
    if (sample_valid) begin
      if (s0 < D) q.push_back({cmd_i, sd_dat_i});
      else movf = 1'b1;
    end
    mvalid = 1'b1;
  endtask
  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) model_reset();
    else model_step();
  end
  initial forever begin
    @(posedge clk);
    if (!rst && tx_valid && tx_ready) txlog.push_back(tx_data);
  end
  initial forever begin
    @(negedge clk);
    chk("tx_valid", tx_valid, mvalid);
    chk("tx_data", tx_data, fb.size() > 0 ? fb[0] : IB);
    chk("in_ready", in_ready, mvalid && q.size() < D);
    chk("overflow", overflow, movf);
    chk("frame_cnt", frame_cnt, mframes);
  end
  function automatic int cur_kind();
    return fk.size() > 0 ? fk[0] : -1;
  endfunction
  function automatic int find_sync();
    foreach (txlog[j]) if (txlog[j] == SB) return j;
    return -1;
  endfunction
  task automatic drive(input bit v, input bit c, input logic [7:0] d, input bit r);
    @(negedge clk);
    sample_valid = v;
    cmd_i = c;
    sd_dat_i = d;
    tx_ready = r;
  endtask
  task automatic idle(input int n, input bit r);
    repeat (n) drive(1'b0, 1'b0, 8'h00, r);
  endtask
  task automatic reach(input int kind, input string nm);
    bit hit;
    hit = 1'b0;
    for (int k = 0; k < 30 && !hit; k++) begin
      @(negedge clk);
      sample_valid = 1'b0;
      if (cur_kind() == kind) begin
        hit = 1'b1;
        tx_ready = 1'b0;
      end else tx_ready = 1'b1;
    end
    chk(nm, hit, 1'b1);
  endtask
  initial begin
    int i;
    logic [7:0] e[6];
    repeat (2) @(negedge clk);
    chk("rst_tx_valid", tx_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_tx_data", tx_data, IB);
    chk("rst_overflow", overflow, 1'b0);
    chk("rst_frame_cnt", frame_cnt, 16'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_tx_valid", tx_valid, 1'b1);
    chk("post_rst_in_ready", in_ready, 1'b1);
    // single-sample frame
    txlog.delete();
`ifdef EMMC_FRAMER_CRC_EN
    drive(1'b1, 1'b1, 8'h5A, 1'b0);
    e = '{8'hA5, 8'h01, 8'h01, 8'h5A, 8'hFF, 8'h3C};
`else
    drive(1'b1, 1'b0, 8'hC3, 1'b0);
    e = '{8'hA5, 8'h01, 8'h00, 8'hC3, 8'h3C, 8'h3C};
`endif
    idle(12, 1'b1);
    i = find_sync();
    chk("single_sync_found", i >= 0, 1'b1);
    if (i < 0) i = 0;
    for (int k = 0; k < 6; k++) chk("single_frame_byte", txlog[i + k], e[k]);
    chk("single_frame_cnt", frame_cnt, 16'd1);
    // stall during PAY_HI
    drive(1'b1, 1'b1, 8'h33, 1'b1);
    reach(2, "reach_pay_hi");
    repeat (5) begin
      @(negedge clk);
      chk("stall_hold", tx_data, 8'h01);
    end
    idle(10, 1'b1);
    // six samples split into 4 + 2
    for (int k = 0; k < 6; k++) drive(1'b1, k[0], 8'h10 + 8'(k), 1'b0);
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    txlog.delete();
    idle(40, 1'b1);
    i = find_sync();
    chk("six_sync_found", i >= 0, 1'b1);
    if (i < 0) i = 0;
    chk("six_count1", txlog[i + 1], 8'h04);
    chk("six_first_hi", txlog[i + 2], 8'h00);
    chk("six_first_lo", txlog[i + 3], 8'h10);
    chk("six_gap_idle", txlog[i + 10 + CB], IB);
    chk("six_sync2", txlog[i + 11 + CB], SB);
    chk("six_count2", txlog[i + 12 + CB], 8'h02);
    chk("six_f2_lo", txlog[i + 14 + CB], 8'h14);
    chk("six_frame_cnt", frame_cnt, 16'd4);
    // overflow on the ninth push
    for (int k = 0; k < 8; k++) drive(1'b1, 1'b0, 8'(k), 1'b0);
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    chk("full_in_ready", in_ready, 1'b0);
    chk("full_no_ovf", overflow, 1'b0);
    drive(1'b1, 1'b1, 8'h99, 1'b0);
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    chk("ovf_set", overflow, 1'b1);
    idle(40, 1'b1);
    chk("ovf_sticky", overflow, 1'b1);
    chk("ovf_frame_cnt", frame_cnt, 16'd6);
    // reset in PAY_LO of a 4-sample frame
    for (int k = 0; k < 4; k++) drive(1'b1, 1'b1, 8'h40 + 8'(k), 1'b0);
    reach(3, "reach_pay_lo");
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_tx_valid", tx_valid, 1'b0);
    chk("mid_rst_in_ready", in_ready, 1'b0);
    chk("mid_rst_tx_data", tx_data, IB);
    chk("mid_rst_overflow", overflow, 1'b0);
    chk("mid_rst_frame_cnt", frame_cnt, 16'h0);
    @(negedge clk);
    tx_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    txlog.delete();
    idle(8, 1'b1);
    chk("after_rst_bytes", txlog.size() >= 4, 1'b1);
    foreach (txlog[j]) chk("after_rst_idle", txlog[j], IB);
    // randomized traffic with occasional resets
    for (int c = 0; c < 3000; c++) begin
      int pv;
      int pr;
      pv = (c / 200) % 3 == 0 ? 20 : ((c / 200) % 3 == 1 ? 50 : 90);
      pr = (c / 300) % 2 == 0 ? 80 : 35;
      drive($urandom_range(0, 99) < pv, 1'($urandom), 8'($urandom), $urandom_range(0, 99) < pr);
      if ($urandom_range(0, 399) == 0) begin
        #2 rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end
    end
    idle(60, 1'b1);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/emmc_link_framer.md
EMMC_LINK_FRAMER -- requirements
Module: emmc_link_framer

Interface
REQ-001 Parameter FIFO_DEPTH, default 8, sample FIFO depth (power of two, 4..32).
REQ-002 Parameter MAX_SAMPLES, default 4, maximum samples per frame (1..15, <= FIFO_DEPTH).
REQ-003 Parameter IDLE_BYTE, default 8'h3C, filler byte sent between frames.
REQ-004 Parameter SYNC_BYTE, default 8'hA5, frame start byte.
REQ-005 Port clk, input, 1, single clock, the serdes txclk_div domain; all logic on rising edge.
REQ-006 Port rst, input, 1, asynchronous active-high reset.
REQ-007 Port sample_valid, input, 1, push request for one eMMC line sample.
REQ-008 Port cmd_i, input, 1, sampled CMD line level.
REQ-009 Port sd_dat_i, input, 8, sampled DAT[7:0] line levels.
REQ-010 Port in_ready, output, 1, high when the FIFO is not full.
REQ-011 Port tx_data, output, 8, byte to the serdes transmitter.
REQ-012 Port tx_valid, output, 1, tx_data valid.
REQ-013 Port tx_ready, input, 1, serdes accepts tx_data this cycle.
REQ-014 Port overflow, output, 1, sticky flag, a sample was dropped.
REQ-015 Port frame_cnt, output, 16, count of completed frames, wraps 0xFFFF->0x0000.

Function
REQ-016 Push accepted iff sample_valid=1 and FIFO not full at the cycle start; {cmd_i, sd_dat_i} stored as a 9-bit entry.
REQ-017 Push when full: sample dropped, overflow set next cycle; a pop in the same cycle does not rescue it.
REQ-018 Handshake: a byte transfers on a cycle with tx_valid=1 and tx_ready=1; tx_data holds unchanged while tx_ready=0.
REQ-019 Registered outputs: tx_data and tx_valid change only on clk edges and never depend combinationally on tx_ready.
REQ-020 FSM states: IDLE, SYNC, COUNT, PAY_HI, PAY_LO, CRC; all transitions occur only on a handshake.
REQ-021 IDLE: tx_data=IDLE_BYTE; on handshake go to SYNC if FIFO non-empty, else stay in IDLE.
REQ-022 SYNC: tx_data=SYNC_BYTE; N=min(FIFO occupancy, MAX_SAMPLES) latched on entry; on handshake go to COUNT.
REQ-023 COUNT: tx_data={4'h0, N[3:0]}; on handshake go to PAY_HI.
REQ-024 PAY_HI: tx_data={7'h00, head.cmd}, no pop; on handshake go to PAY_LO.
REQ-025 PAY_LO: tx_data=head.dat; on handshake pop and decrement the remaining count; go to PAY_HI if more samples remain, else go to CRC (or IDLE when CRC is compiled out).
REQ-026 CRC: tx_data=CRC-8 (poly 0x07, init 0x00, MSB first, no reflection, no xorout) over the COUNT byte and all payload bytes, SYNC excluded; on handshake go to IDLE.
REQ-027 frame_cnt increments on the handshake of the final frame byte.
REQ-028 Pushes during a frame are allowed; N is not extended after it is latched.
REQ-029 Simultaneous push and pop with FIFO not full: both take effect and occupancy is unchanged.
REQ-030 Frame latency: with tx_ready held high, a sample pushed into an empty FIFO while in IDLE appears as the SYNC byte within 2 cycles.

Reset
REQ-031 Asserting rst, at any point including mid-frame, immediately forces: FSM=IDLE, FIFO empty, tx_data=IDLE_BYTE, tx_valid=0, in_ready=0, overflow=0, frame_cnt=0, CRC=0x00.
REQ-032 First clk edge after deassertion: tx_valid=1 and in_ready=1; tx_valid then stays high until the next reset.
REQ-033 A partial frame interrupted by reset is abandoned and is never resumed.

Configuration
REQ-034 Macro EMMC_FRAMER_CRC_EN defined: the CRC state and trailing CRC byte are present.
REQ-035 Macro EMMC_FRAMER_CRC_EN undefined: no CRC logic, and the frame ends after the last PAY_LO byte.

Verification
REQ-036 One sample (cmd=1, dat=0x5A), tx_ready=1 -> bytes A5 01 01 5A FF then 3C; frame_cnt=1.
REQ-037 Six samples queued while tx_ready=0, then tx_ready=1 -> frame with COUNT=04 and 4 sample pairs, then frame with COUNT=02 and 2 pairs; frame_cnt=2.
REQ-038 tx_ready low for 5 cycles during PAY_HI -> tx_data stable for all 5 cycles, and no pop occurs.
REQ-039 Nine pushes with tx_ready=0 (FIFO_DEPTH=8) -> ninth dropped, in_ready=0, overflow=1 and stays 1.
REQ-040 rst asserted during PAY_LO of a 4-sample frame -> all outputs at REQ-031 values; after release, 3C bytes are sent until new pushes arrive.
REQ-041 Build without EMMC_FRAMER_CRC_EN, one sample (cmd=0, dat=0xC3) -> bytes A5 01 00 C3 then 3C.
